// File: rtl/mem_pkg.sv
// Shared encodings and helpers for the MEM stage: access sizes, FSM states,
// byte-enable generation and load-data extension.
package mem_pkg;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_RSP  = 2'd2;

    // Lane mask of (1 << sz) bytes starting at byte offset off, 8-lane view.
    function automatic logic [7:0] be_mask(input logic [1:0] sz, input logic [2:0] off);
        return 8'(((16'h1 << (4'h1 << sz)) - 16'h1) << off);
    endfunction

    function automatic logic [63:0] extend(input logic [63:0] v, input logic [1:0] sz,
                                           input logic uns);
        case (sz)
            SZ_B:    return uns ? {56'b0, v[7:0]}  : {{56{v[7]}},  v[7:0]};
            SZ_H:    return uns ? {48'b0, v[15:0]} : {{48{v[15]}}, v[15:0]};
            SZ_W:    return uns ? {32'b0, v[31:0]} : {{32{v[31]}}, v[31:0]};
            default: return v;
        endcase
    endfunction

endpackage

// File: rtl/mem_load_align.sv
// Combinational load path: shift the addressed bytes down to bit 0, then
// mask to the access size and sign/zero extend.
module mem_load_align
    import mem_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int OFF_W  = (DATA_W == 64) ? 3 : 2
) (
    input  logic [DATA_W-1:0] rdata_i,
    input  logic [OFF_W-1:0]  off_i,
    input  logic [1:0]        size_i,
    input  logic              unsigned_i,
    output logic [DATA_W-1:0] data_o
);

    logic [DATA_W-1:0] shifted;

    assign shifted = rdata_i >> {off_i, 3'b000};
    assign data_o  = DATA_W'(extend(64'(shifted), size_i, unsigned_i));

endmodule

// File: rtl/mem_stage_hs.sv
// MEM stage with MEM/WB register and req/gnt + rvalid data-memory handshake.
// MEM_STAGE_MISALIGN_EXC_EN: trap misaligned accesses instead of aligning them.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | no access outstanding; a new op requests combinationally
// ST_REQ   | request presented but not yet granted, fields held
// ST_RSP   | load granted, waiting for d_rvalid
module mem_stage_hs
    import mem_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int REG_W  = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    input  logic                mem_read,
    input  logic                mem_write,
    input  logic [1:0]          mem_size,
    input  logic                mem_unsigned,
    input  logic [DATA_W-1:0]   alu_result,
    input  logic [DATA_W-1:0]   B,
    input  logic [REG_W-1:0]    dst_reg,
    input  logic                wb_reg_write,
    input  logic                wb_mem_to_reg,
    output logic                stall,
    output logic                MEM_WB_valid,
    output logic [REG_W-1:0]    MEM_WB_dst_reg,
    output logic                MEM_WB_reg_write,
    output logic                MEM_WB_mem_to_reg,
    output logic [DATA_W-1:0]   MEM_WB_mem_out,
    output logic [DATA_W-1:0]   MEM_WB_alu_out,
`ifdef MEM_STAGE_MISALIGN_EXC_EN
    output logic                MEM_WB_exc,
    output logic [DATA_W-1:0]   MEM_WB_bad_addr,
`endif
    output logic                d_req,
    input  logic                d_gnt,
    output logic                d_we,
    output logic [ADDR_W-1:0]   d_addr,
    output logic [DATA_W/8-1:0] d_be,
    output logic [DATA_W-1:0]   d_wdata,
    input  logic                d_rvalid,
    input  logic [DATA_W-1:0]   d_rdata
);

    localparam int NB    = DATA_W / 8;
    localparam int OFF_W = (DATA_W == 64) ? 3 : 2;

    logic [1:0]        size_eff;
    logic [OFF_W-1:0]  size_mask;
    logic [OFF_W-1:0]  off;
    logic              exc;
    logic              op;
    logic [DATA_W-1:0] load_data;
    logic [DATA_W-1:0] mem_out_d;

    logic [1:0]        state_q, state_d;
    logic              req_d;
    logic              done;

    logic              valid_q;
    logic [REG_W-1:0]  dst_q;
    logic              reg_write_q;
    logic              mem_to_reg_q;
    logic [DATA_W-1:0] mem_out_q;
    logic [DATA_W-1:0] alu_q;

    // A 32-bit datapath has no doubleword; D degrades to W.
    assign size_eff  = (DATA_W == 32 && mem_size == SZ_D) ? SZ_W : mem_size;
    assign size_mask = OFF_W'((4'h1 << size_eff) - 4'h1);

`ifdef MEM_STAGE_MISALIGN_EXC_EN
    logic              exc_q;
    logic [DATA_W-1:0] bad_addr_q;

    assign off = alu_result[OFF_W-1:0];
    assign exc = in_valid & (mem_read | mem_write) & (|(off & size_mask));
`else
    assign off = alu_result[OFF_W-1:0] & ~size_mask;
    assign exc = 1'b0;
`endif

    assign op = in_valid & (mem_read | mem_write) & ~exc;

    always_comb begin
        state_d = state_q;
        req_d   = 1'b0;
        done    = 1'b0;
        stall   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (op) begin
                    req_d = 1'b1;
                    if (d_gnt && mem_write) begin
                        done = 1'b1;
                    end else if (d_gnt) begin
                        state_d = ST_RSP;
                        stall   = 1'b1;
                    end else begin
                        state_d = ST_REQ;
                        stall   = 1'b1;
                    end
                end
            end
            ST_REQ: begin
                req_d = 1'b1;
                if (d_gnt && mem_write) begin
                    done    = 1'b1;
                    state_d = ST_IDLE;
                end else if (d_gnt) begin
                    state_d = ST_RSP;
                    stall   = 1'b1;
                end else begin
                    stall = 1'b1;
                end
            end
            ST_RSP: begin
                if (d_rvalid) begin
                    done    = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    stall = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Gate with reset so a held op cannot request while the stage is in reset.
    assign d_req  = req_d & rst_n;
    assign d_we   = mem_write;
    assign d_addr = ADDR_W'(alu_result) & ~ADDR_W'(NB - 1);
    assign d_be   = NB'(be_mask(size_eff, 3'(off)));

    always_comb begin
        d_wdata = B;
        case (size_eff)
            SZ_B:    d_wdata = {NB{B[7:0]}};
            SZ_H:    d_wdata = {(NB/2){B[15:0]}};
            SZ_W:    d_wdata = {(NB/4){B[31:0]}};
            default: d_wdata = B;
        endcase
    end

    mem_load_align #(
        .DATA_W (DATA_W),
        .OFF_W  (OFF_W)
    ) u_load_align (
        .rdata_i    (d_rdata),
        .off_i      (off),
        .size_i     (size_eff),
        .unsigned_i (mem_unsigned),
        .data_o     (load_data)
    );

    assign mem_out_d = (in_valid && mem_read && !exc) ? load_data : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            valid_q      <= 1'b0;
            dst_q        <= '0;
            reg_write_q  <= 1'b0;
            mem_to_reg_q <= 1'b0;
            mem_out_q    <= '0;
            alu_q        <= '0;
`ifdef MEM_STAGE_MISALIGN_EXC_EN
            exc_q        <= 1'b0;
            bad_addr_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            if (stall) begin
                valid_q     <= 1'b0;
                reg_write_q <= 1'b0;
`ifdef MEM_STAGE_MISALIGN_EXC_EN
                exc_q       <= 1'b0;
`endif
            end else begin
                valid_q      <= in_valid;
                reg_write_q  <= wb_reg_write & in_valid & ~exc;
                dst_q        <= dst_reg;
                mem_to_reg_q <= wb_mem_to_reg;
                mem_out_q    <= mem_out_d;
                alu_q        <= alu_result;
`ifdef MEM_STAGE_MISALIGN_EXC_EN
                exc_q        <= exc;
                bad_addr_q   <= exc ? alu_result : '0;
`endif
            end
        end
    end

    assign MEM_WB_valid      = valid_q;
    assign MEM_WB_dst_reg    = dst_q;
    assign MEM_WB_reg_write  = reg_write_q;
    assign MEM_WB_mem_to_reg = mem_to_reg_q;
    assign MEM_WB_mem_out    = mem_out_q;
    assign MEM_WB_alu_out    = alu_q;
`ifdef MEM_STAGE_MISALIGN_EXC_EN
    assign MEM_WB_exc        = exc_q;
    assign MEM_WB_bad_addr   = bad_addr_q;
`endif

endmodule

// File: tb/tb_mem_stage_hs.sv
// Directed bench for mem_stage_hs (DATA_W=32): stores, sub-word loads, wait
// states, reset mid-access and misaligned word load.
module tb_mem_stage_hs;

    logic        clk, rst_n;
    logic        in_valid, mem_read, mem_write, mem_unsigned;
    logic [1:0]  mem_size;
    logic [31:0] alu_result, B;
    logic [4:0]  dst_reg;
    logic        wb_reg_write, wb_mem_to_reg;
    logic        stall, MEM_WB_valid, MEM_WB_reg_write, MEM_WB_mem_to_reg;
    logic [4:0]  MEM_WB_dst_reg;
    logic [31:0] MEM_WB_mem_out, MEM_WB_alu_out;
`ifdef MEM_STAGE_MISALIGN_EXC_EN
    logic        MEM_WB_exc;
    logic [31:0] MEM_WB_bad_addr;
`endif
    logic        d_req, d_gnt, d_we, d_rvalid;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic [3:0]  d_be;

    int n_cmp = 0;
    int n_bad = 0;
    int stalls;

    mem_stage_hs dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .in_valid          (in_valid),
        .mem_read          (mem_read),
        .mem_write         (mem_write),
        .mem_size          (mem_size),
        .mem_unsigned      (mem_unsigned),
        .alu_result        (alu_result),
        .B                 (B),
        .dst_reg           (dst_reg),
        .wb_reg_write      (wb_reg_write),
        .wb_mem_to_reg     (wb_mem_to_reg),
        .stall             (stall),
        .MEM_WB_valid      (MEM_WB_valid),
        .MEM_WB_dst_reg    (MEM_WB_dst_reg),
        .MEM_WB_reg_write  (MEM_WB_reg_write),
        .MEM_WB_mem_to_reg (MEM_WB_mem_to_reg),
        .MEM_WB_mem_out    (MEM_WB_mem_out),
        .MEM_WB_alu_out    (MEM_WB_alu_out),
`ifdef MEM_STAGE_MISALIGN_EXC_EN
        .MEM_WB_exc        (MEM_WB_exc),
        .MEM_WB_bad_addr   (MEM_WB_bad_addr),
`endif
        .d_req             (d_req),
        .d_gnt             (d_gnt),
        .d_we              (d_we),
        .d_addr            (d_addr),
        .d_be              (d_be),
        .d_wdata           (d_wdata),
        .d_rvalid          (d_rvalid),
        .d_rdata           (d_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected $finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_op(input logic v, input logic rd, input logic wr, input logic [1:0] sz,
                          input logic uns, input logic [31:0] alu, input logic [31:0] b,
                          input logic [4:0] dst, input logic rw, input logic m2r);
        in_valid = v; mem_read = rd; mem_write = wr; mem_size = sz; mem_unsigned = uns;
        alu_result = alu; B = b; dst_reg = dst; wb_reg_write = rw; wb_mem_to_reg = m2r;
    endtask

    initial begin
        rst_n = 1'b0; d_gnt = 1'b0; d_rvalid = 1'b0; d_rdata = '0;
        set_op(1, 0, 1, 2'd2, 0, 32'h100, 32'h0, 5'd0, 0, 0);
        repeat (2) @(negedge clk);
        #1;
        chk("rst_d_req", d_req, 0);
        chk("rst_valid", MEM_WB_valid, 0);
        chk("rst_mem_out", MEM_WB_mem_out, 0);
        chk("rst_alu_out", MEM_WB_alu_out, 0);

        // SW 0xDEADBEEF @0x100, granted immediately
        @(negedge clk);
        rst_n = 1'b1;
        set_op(1, 0, 1, 2'd2, 0, 32'h100, 32'hDEADBEEF, 5'd0, 0, 0);
        d_gnt = 1'b1;
        #1;
        chk("sw_req", d_req, 1);
        chk("sw_we", d_we, 1);
        chk("sw_be", d_be, 4'hF);
        chk("sw_addr", d_addr, 32'h100);
        chk("sw_wdata", d_wdata, 32'hDEADBEEF);
        chk("sw_stall", stall, 0);
        @(posedge clk); #1;
        chk("sw_valid", MEM_WB_valid, 1);
        chk("sw_rw", MEM_WB_reg_write, 0);
        chk("sw_memout", MEM_WB_mem_out, 0);

        // SB @0x103
        @(negedge clk);
        set_op(1, 0, 1, 2'd0, 0, 32'h103, 32'h12345678, 5'd0, 0, 0);
        #1;
        chk("sb_be", d_be, 4'b1000);
        chk("sb_wdata", d_wdata, 32'h78787878);
        chk("sb_addr", d_addr, 32'h100);
        @(posedge clk);

        // SH @0x102 with one wait state before grant
        @(negedge clk);
        set_op(1, 0, 1, 2'd1, 0, 32'h102, 32'h12345678, 5'd0, 0, 0);
        d_gnt = 1'b0;
        #1;
        chk("sh_be", d_be, 4'b1100);
        chk("sh_wdata", d_wdata, 32'h56785678);
        chk("sh_stall0", stall, 1);
        @(posedge clk); #1;
        chk("sh_bubble", MEM_WB_valid, 0);
        @(negedge clk);
        d_gnt = 1'b1;
        #1;
        chk("sh_req1", d_req, 1);
        chk("sh_stall1", stall, 0);
        @(posedge clk); #1;
        chk("sh_valid", MEM_WB_valid, 1);

        // LB @0x101, sign-extended
        @(negedge clk);
        set_op(1, 1, 0, 2'd0, 0, 32'h101, 32'h0, 5'd3, 1, 1);
        d_gnt = 1'b1;
        #1;
        chk("lb_we", d_we, 0);
        chk("lb_be", d_be, 4'b0010);
        chk("lb_stall0", stall, 1);
        @(posedge clk); #1;
        chk("lb_bubble", MEM_WB_valid, 0);
        @(negedge clk);
        d_gnt = 1'b0; d_rvalid = 1'b1; d_rdata = 32'h00008000;
        #1;
        chk("lb_rsp_req", d_req, 0);
        chk("lb_rsp_stall", stall, 0);
        @(posedge clk); #1;
        chk("lb_valid", MEM_WB_valid, 1);
        chk("lb_out", MEM_WB_mem_out, 32'hFFFFFF80);
        chk("lb_rw", MEM_WB_reg_write, 1);
        chk("lb_dst", MEM_WB_dst_reg, 5'd3);
        chk("lb_m2r", MEM_WB_mem_to_reg, 1);

        // LBU @0x101
        @(negedge clk);
        set_op(1, 1, 0, 2'd0, 1, 32'h101, 32'h0, 5'd4, 1, 1);
        d_gnt = 1'b1; d_rvalid = 1'b0;
        @(negedge clk);
        d_gnt = 1'b0; d_rvalid = 1'b1;
        @(posedge clk); #1;
        chk("lbu_out", MEM_WB_mem_out, 32'h00000080);

        // LHU @0x102: grant in 4th cycle, rvalid two cycles after
        stalls = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i == 0) set_op(1, 1, 0, 2'd1, 1, 32'h102, 32'h0, 5'd5, 1, 1);
            d_gnt = (i == 3); d_rvalid = (i == 5); d_rdata = 32'hBEEF1234;
            #1;
            if (stall) stalls++;
            chk("lhu_req", d_req, (i <= 3) ? 1 : 0);
            if (i <= 3) chk("lhu_addr", d_addr, 32'h100);
            @(posedge clk); #1;
            if (i < 5) chk("lhu_bubble", MEM_WB_valid, 0);
        end
        chk("lhu_stalls", stalls, 5);
        chk("lhu_out", MEM_WB_mem_out, 32'h0000BEEF);
        chk("lhu_valid", MEM_WB_valid, 1);

        // LH @0x102, sign-extended
        @(negedge clk);
        set_op(1, 1, 0, 2'd1, 0, 32'h102, 32'h0, 5'd6, 1, 1);
        d_gnt = 1'b1; d_rvalid = 1'b0; d_rdata = 32'h80001234;
        @(negedge clk);
        d_gnt = 1'b0; d_rvalid = 1'b1;
        @(posedge clk); #1;
        chk("lh_out", MEM_WB_mem_out, 32'hFFFF8000);

        // Non-memory instruction passes in one cycle
        @(negedge clk);
        set_op(1, 0, 0, 2'd2, 0, 32'h55, 32'h0, 5'd7, 1, 0);
        d_rvalid = 1'b0;
        #1;
        chk("alu_stall", stall, 0);
        chk("alu_req", d_req, 0);
        @(posedge clk); #1;
        chk("alu_valid", MEM_WB_valid, 1);
        chk("alu_rw", MEM_WB_reg_write, 1);
        chk("alu_memout", MEM_WB_mem_out, 0);
        chk("alu_aluout", MEM_WB_alu_out, 32'h55);
        chk("alu_dst", MEM_WB_dst_reg, 5'd7);

        // Invalid slot: reg_write gated off
        @(negedge clk);
        set_op(0, 0, 0, 2'd2, 0, 32'h66, 32'h0, 5'd8, 1, 0);
        @(posedge clk); #1;
        chk("inv_valid", MEM_WB_valid, 0);
        chk("inv_rw", MEM_WB_reg_write, 0);

        // Load in RSP abandoned by reset, then reissued
        @(negedge clk);
        set_op(1, 1, 0, 2'd2, 0, 32'h104, 32'h0, 5'd9, 1, 1);
        d_gnt = 1'b1;
        @(posedge clk); #1;
        chk("rr_alu_held", MEM_WB_alu_out, 32'h66);
        @(negedge clk);
        d_gnt = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rr_req", d_req, 0);
        chk("rr_alu_out", MEM_WB_alu_out, 0);
        chk("rr_valid", MEM_WB_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rr_idle_req", d_req, 1);
        chk("rr_idle_stall", stall, 1);
        d_gnt = 1'b1;
        @(negedge clk);
        d_gnt = 1'b0; d_rvalid = 1'b1; d_rdata = 32'hCAFEF00D;
        #1;
        chk("rr_rsp_stall", stall, 0);
        @(posedge clk); #1;
        chk("rr_out", MEM_WB_mem_out, 32'hCAFEF00D);
        chk("rr_valid2", MEM_WB_valid, 1);

        // LW @0x102: misaligned word
        @(negedge clk);
        set_op(1, 1, 0, 2'd2, 0, 32'h102, 32'h0, 5'd10, 1, 1);
        d_rvalid = 1'b0; d_rdata = 32'h11223344;
`ifdef MEM_STAGE_MISALIGN_EXC_EN
        #1;
        chk("mis_req", d_req, 0);
        chk("mis_stall", stall, 0);
        @(posedge clk); #1;
        chk("mis_valid", MEM_WB_valid, 1);
        chk("mis_rw", MEM_WB_reg_write, 0);
        chk("mis_exc", MEM_WB_exc, 1);
        chk("mis_bad", MEM_WB_bad_addr, 32'h102);
`else
        d_gnt = 1'b1;
        #1;
        chk("mis_req", d_req, 1);
        chk("mis_addr", d_addr, 32'h100);
        chk("mis_be", d_be, 4'hF);
        @(negedge clk);
        d_gnt = 1'b0; d_rvalid = 1'b1;
        @(posedge clk); #1;
        chk("mis_out", MEM_WB_mem_out, 32'h11223344);
`endif

        @(negedge clk);
        set_op(0, 0, 0, 2'd0, 0, 32'h0, 32'h0, 5'd0, 0, 0);
        d_rvalid = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
